// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned ITER_LAST = DIV_WIDTH - 1;
  localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dividend_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // The remainder top bit is always 0 between steps; widening keeps the compare exact.
  assign shifted = {rem_i, dividend_msb_i};
  assign diff    = shifted[WIDTH:0] - {1'b0, divisor_i};

  always_comb begin
    q_bit_o = 1'b0;
    rem_o   = shifted[WIDTH:0];
    if (shifted >= {2'b00, divisor_i}) begin
      q_bit_o = 1'b1;
      rem_o   = diff;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle instead of a full pass.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               mul_clk,
  input  logic               resetn,
  input  logic               div_i,
  input  logic               div_signed_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               complete_o
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER_LAST);
  localparam logic [WIDTH-1:0] DzQuot = WIDTH'(DIVZERO_Q);

  div_state_e       state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dz_q;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_src;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign x_neg = div_signed_i & x_i[WIDTH-1];
  assign y_neg = div_signed_i & y_i[WIDTH-1];
  assign x_mag = x_neg ? -x_i : x_i;
  assign y_mag = y_neg ? -y_i : y_i;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i          (rem_q),
    .dividend_msb_i (dvd_q[WIDTH-1]),
    .divisor_i      (dvs_q),
    .rem_o          (rem_nxt),
    .q_bit_o        (q_bit)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  assign quo_nxt = {dvd_q[WIDTH-2:0], q_bit};

`ifdef DIV_ZERO_FAST_EN
  // Fast path runs a single step, so |x| is still intact in the dividend register.
  assign rem_src = dz_q ? dvd_q : rem_nxt[WIDTH-1:0];
`else
  assign rem_src = rem_nxt[WIDTH-1:0];
`endif

  // Re-applying x's sign to |x| recovers x exactly for the divide-by-zero remainder.
  assign quo_fix = dz_q ? DzQuot : (sign_q_q ? -quo_nxt : quo_nxt);
  assign rem_fix = sign_r_q ? -rem_src : rem_src;

  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      dz_q       <= 1'b0;
      result_o   <= '0;
      complete_o <= 1'b0;
    end else begin
      complete_o <= 1'b0;
      unique case (state_q)
        DIV_IDLE: begin
          if (div_i) begin
            sign_q_q <= div_signed_i & (x_i[WIDTH-1] ^ y_i[WIDTH-1]);
            sign_r_q <= x_neg;
            dvd_q    <= x_mag;
            dvs_q    <= y_mag;
            rem_q    <= '0;
            dz_q     <= (y_i == '0);
            count_q  <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (y_i == '0) begin
              count_q <= LastCnt;
            end
`endif
            state_q  <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (!div_i) begin
            state_q <= DIV_IDLE;
          end else begin
            rem_q   <= rem_nxt;
            dvd_q   <= quo_nxt;
            count_q <= count_q + CntW'(1);
            if (count_q == LastCnt) begin
              result_o   <= {rem_fix, quo_fix};
              complete_o <= 1'b1;
              state_q    <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule
